// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches to a
// variable-latency instruction memory, buffers returned words in a small FIFO
// and hands them to the decoder over valid/ready. A redirect flushes the buffer,
// restarts fetch at the target and drains stale responses.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect -> HALT).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_FLUSH = 2'd1, ST_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_FLUSH = 2'd1} state_t;
`endif

    state_t          state_r;
    state_t          state_nxt_s;
    logic [31:0]     fetch_pc_r;
    logic [31:0]     fetch_pc_nxt_s;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   in_flight_s;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [31:0]     pc_mem_r   [FIFO_DEPTH];
    logic [31:0]     word_mem_r [FIFO_DEPTH];
    logic            fault_r;
    logic            fault_nxt_s;
    logic            req_s;
    logic            accept_s;
    logic            rsp_s;
    logic            redirect_s;
    logic            misalign_s;
    logic            push_s;
    logic            pop_s;
    logic            valid_s;
    logic [31:0]     rsp_pc_s;
    logic [31:0]     target_s;

    // Outstanding responses are always the youngest contiguous PCs below
    // fetch_pc, so the oldest one's PC follows from the outstanding count.
    assign in_flight_s = outstanding_r + count_r;
    assign rsp_pc_s    = fetch_pc_r - {{(30-CW){1'b0}}, outstanding_r, 2'b00};
    assign target_s    = redirect_pc & 32'hFFFF_FFFC;

    // Next-state, request gating and buffer control
    always_comb begin
        req_s             = 1'b0;
        accept_s          = 1'b0;
        rsp_s             = 1'b0;
        redirect_s        = 1'b0;
        misalign_s        = 1'b0;
        push_s            = 1'b0;
        pop_s             = 1'b0;
        valid_s           = 1'b0;
        fault_nxt_s       = fault_r;
        state_nxt_s       = state_r;
        fetch_pc_nxt_s    = fetch_pc_r;
        outstanding_nxt_s = outstanding_r;

        case (state_r)
            ST_FETCH: req_s = (in_flight_s < CW'(FIFO_DEPTH));
            default:  req_s = 1'b0;
        endcase

        accept_s = req_s && imem_ready;
        rsp_s    = imem_rvalid && ((outstanding_r != {CW{1'b0}}) || accept_s);
        outstanding_nxt_s = outstanding_r + CW'(accept_s) - CW'(rsp_s);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_s = redirect_valid && (state_r != ST_HALT);
        misalign_s = (redirect_pc[1:0] != 2'b00);
        valid_s    = (count_r != {CW{1'b0}}) && (state_r != ST_HALT);
`else
        redirect_s = redirect_valid;
        misalign_s = 1'b0;
        valid_s    = (count_r != {CW{1'b0}});
`endif

        push_s = rsp_s && (state_r == ST_FETCH) && !redirect_s;
        pop_s  = valid_s && instr_ready && !redirect_s;

        if (redirect_s) begin
            fetch_pc_nxt_s = target_s;
        end else if (accept_s) begin
            fetch_pc_nxt_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end

        case (state_r)
            ST_FETCH, ST_FLUSH: begin
                if (redirect_s && misalign_s) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    state_nxt_s = ST_HALT;
                    fault_nxt_s = 1'b1;
`else
                    state_nxt_s = ST_FETCH;
`endif
                end else if (redirect_s) begin
                    state_nxt_s = (outstanding_nxt_s != {CW{1'b0}}) ? ST_FLUSH : ST_FETCH;
                end else if (state_r == ST_FLUSH) begin
                    state_nxt_s = (outstanding_nxt_s == {CW{1'b0}}) ? ST_FETCH : ST_FLUSH;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            ST_HALT: state_nxt_s = ST_HALT;
`endif
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // Control registers: FSM state, PC, outstanding count, fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_FETCH;
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            fault_r       <= fault_nxt_s;
        end
    end

    // Instruction buffer: storage, pointers and occupancy; redirect empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= {CW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                word_mem_r[i] <= 32'h0000_0000;
            end
        end else if (redirect_s) begin
            count_r  <= {CW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= rsp_pc_s;
                word_mem_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r             <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_r;
    assign instr_valid = valid_s;
    assign instr_out   = word_mem_r[rd_ptr_r];
    assign instr_pc    = pc_mem_r[rd_ptr_r];
    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order variable-latency memory model
// plus an expected-PC-stream model of the fetch/decoder contract.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1, lat_max = 1;
    int          ready_pct = 100, iready_pct = 100;
    int          acc_total = 0;
    logic [31:0] exp_pc, exp_addr;
    bit          halted;
    bit          prev_hold, prev_redirect, prev_last_stale, saw_wrap;
    logic [31:0] prev_out, prev_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit any_stale();
        foreach (q[i]) if (q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    // Reset (async), check reset outputs, release on a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_out", instr_out, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_fault", {31'h0, fetch_fault}, 32'h0);
        q.delete();
        exp_pc = RESET_PC; exp_addr = RESET_PC; halted = 1'b0;
        prev_hold = 1'b0; prev_redirect = 1'b0; prev_last_stale = 1'b0;
        last_due = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    // One cycle: drive inputs at negedge, check outputs, update models after posedge
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit   acc, rv, pop, st;
        req_t r;
        int   due;
        imem_ready  = ($urandom_range(99) < ready_pct);
        instr_ready = ($urandom_range(99) < iready_pct);
        rv = (q.size() > 0) && (q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? q[0].addr + 32'h13 : 32'h0;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        if (prev_redirect) check("flush_valid", {31'h0, instr_valid}, 32'h0);
        if (prev_hold) begin
            check("hold_out", instr_out, prev_out);
            check("hold_pc", instr_pc, prev_pc);
        end
        if (any_stale()) check("flush_noreq", {31'h0, imem_req}, 32'h0);
        if (prev_last_stale && !halted) check("flush_exit_req", {31'h0, imem_req}, 32'h1);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("fault", {31'h0, fetch_fault}, {31'h0, halted});
        if (halted) begin
            check("halt_noreq", {31'h0, imem_req}, 32'h0);
            check("halt_novalid", {31'h0, instr_valid}, 32'h0);
        end
`else
        check("fault", {31'h0, fetch_fault}, 32'h0);
`endif
        pop = instr_valid && instr_ready;
        if (pop && !redir) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr_out", instr_out, exp_pc + 32'h13);
            exp_pc = exp_pc + 32'd4;
        end
        acc = imem_req && imem_ready;
        if (acc) begin
            check("req_addr", imem_addr, exp_addr);
            if (imem_addr == 32'h0 && exp_addr == 32'h0 && cyc > 5) saw_wrap = 1'b1;
            exp_addr = exp_addr + 32'd4;
            acc_total++;
        end
        check("outstanding_cap", q.size(), FIFO_DEPTH + (acc ? 1 : 0) > q.size() ? q.size() : FIFO_DEPTH);
        prev_hold = instr_valid && !instr_ready && !redir;
        prev_out = instr_out;
        prev_pc = instr_pc;
        prev_redirect = redir && !halted;
        @(posedge clk);
        st = 1'b0;
        if (rv) begin
            r = q.pop_front();
            st = r.stale;
        end
        if (acc) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q.push_back('{addr: imem_addr, due: due, stale: 1'b0});
        end
        if (redir && !halted) begin
            foreach (q[i]) q[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) halted = 1'b1;
`endif
            exp_pc = tgt & 32'hFFFF_FFFC;
            exp_addr = tgt & 32'hFFFF_FFFC;
        end
        prev_last_stale = st && !any_stale();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        bit          found;
        int          acc0;
        logic [31:0] t;
        saw_wrap = 1'b0;
        #2;
        do_reset();

        // Single-cycle memory, decoder always ready
        lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
        check("stream_progress", {31'h0, (exp_pc >= 32'h20)}, 32'h1);

        // Decoder stalls: requests capped, head holds
        iready_pct = 0;
        acc0 = acc_total;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check("stall_accepts", {31'h0, ((acc_total - acc0) <= FIFO_DEPTH)}, 32'h1);
        check("stall_req_low", {31'h0, imem_req}, 32'h0);
        check("stall_valid", {31'h0, instr_valid}, 32'h1);

        // Redirect with FIFO_DEPTH requests outstanding on 3-cycle memory
        lat_min = 3; lat_max = 3; iready_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (q.size() == FIFO_DEPTH && !any_stale()) begin
                step(1'b1, 32'h0000_0100);
                found = 1'b1;
            end else begin
                step(1'b0, 32'h0);
            end
        end
        check("redir_outstanding_found", {31'h0, found}, 32'h1);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
        check("redir_resumed", {31'h0, (exp_pc > 32'h100)}, 32'h1);

        // Redirect coinciding with a fresh response and a pop
        lat_min = 1; lat_max = 2; ready_pct = 80; iready_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (q.size() > 0 && q[0].due <= cyc && !any_stale() && instr_valid) begin
                step(1'b1, 32'h0000_0400);
                found = 1'b1;
            end else begin
                step(1'b0, 32'h0);
            end
        end
        check("coincide_found", {31'h0, found}, 32'h1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
        check("coincide_resumed", {31'h0, (exp_pc > 32'h400)}, 32'h1);

        // Random traffic with occasional aligned redirects
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            ready_pct  = 50 + int'($urandom_range(50));
            iready_pct = 40 + int'($urandom_range(60));
            t = $urandom() & 32'h0FFF_FFFC;
            step($urandom_range(99) < 4, t);
        end

        // PC wrap past 0xFFFF_FFFC
        lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100;
        step(1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 14; i++) step(1'b0, 32'h0);
        check("wrap_seen", {31'h0, saw_wrap}, 32'h1);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);

        // Misaligned redirect
        step(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0200);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        check("halt_final_fault", {31'h0, fetch_fault}, 32'h1);
        check("halt_final_req", {31'h0, imem_req}, 32'h0);
`else
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check("misalign_resumed", {31'h0, (exp_pc > 32'h100 && exp_pc < 32'h200)}, 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
